synth_reg_arbiter: RTL and testbench

- Shares the synth parameter register bus between two requesters: the MIDI controller (port m_) and the host CPU bridge (port h_).
- The bus consists of adr, write, read, the osc/com/m1/m2 selects, synth_data_in and mixer_regdata_out, and is served by the mixer's control-data register file.
- Per request, the block arbitrates, sequences exactly one single-beat register access, waits the read latency, and returns an ack, optional read data and an error flag.
- It sits between the MIDI/host front ends and mixer_2 in the synth_engine.

---
 rtl/synth_reg_arbiter.sv | 164 ++++++++++++++++
 tb/tb_synth_reg_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/synth_reg_arbiter.sv
// Shares the synth parameter register bus between the MIDI controller (m_) and the host
// bridge (h_), sequencing one single-beat register access per granted request.
module synth_reg_arbiter #(
  parameter int unsigned RD_LAT    = 1,
  parameter bit          MIDI_PRIO = 1'b0
) (
  input  logic       reg_clk,
  input  logic       reset_reg_N,
  input  logic       m_req,
  input  logic       m_we,
  input  logic [3:0] m_sel,
  input  logic [6:0] m_adr,
  input  logic [7:0] m_wdata,
  output logic       m_ack,
  output logic       m_err,
  output logic [7:0] m_rdata,
  input  logic       h_req,
  input  logic       h_we,
  input  logic [3:0] h_sel,
  input  logic [6:0] h_adr,
  input  logic [7:0] h_wdata,
  output logic       h_ack,
  output logic       h_err,
  output logic [7:0] h_rdata,
  output logic [6:0] adr,
  output logic       write,
  output logic       read,
  output logic       osc_sel,
  output logic       com_sel,
  output logic       m1_sel,
  output logic       m2_sel,
  output logic [7:0] synth_data_in,
  input  logic [7:0] mixer_regdata_out,
  output logic       busy,
  output logic       gnt_host
);

  typedef enum logic [2:0] {StIdle, StCheck, StAccess, StWait, StDone} state_e;

  localparam logic [2:0] RdLatCnt = 3'(RD_LAT);

  state_e     state_q;
  logic       last_host_q;
  logic       we_q;
  logic [3:0] sel_q;
  logic [6:0] adr_q;
  logic [7:0] wdata_q;
  logic [2:0] cnt_q;

  logic pick_host;
  logic sel_ok;

  // Round-robin favours whichever port was not granted last; reset leaves host as "last".
  always_comb begin
    pick_host = h_req & (~m_req | (~MIDI_PRIO & ~last_host_q));
    sel_ok    = (sel_q != 4'd0) && ((sel_q & (sel_q - 4'd1)) == 4'd0);
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q       <= StIdle;
      last_host_q   <= 1'b1;
      we_q          <= 1'b0;
      sel_q         <= 4'd0;
      adr_q         <= 7'd0;
      wdata_q       <= 8'd0;
      cnt_q         <= 3'd0;
      m_ack         <= 1'b0;
      m_err         <= 1'b0;
      m_rdata       <= 8'd0;
      h_ack         <= 1'b0;
      h_err         <= 1'b0;
      h_rdata       <= 8'd0;
      adr           <= 7'd0;
      write         <= 1'b0;
      read          <= 1'b0;
      osc_sel       <= 1'b0;
      com_sel       <= 1'b0;
      m1_sel        <= 1'b0;
      m2_sel        <= 1'b0;
      synth_data_in <= 8'd0;
      busy          <= 1'b0;
      gnt_host      <= 1'b0;
    end else begin
      m_ack <= 1'b0;
      h_ack <= 1'b0;
      m_err <= 1'b0;
      h_err <= 1'b0;
      write <= 1'b0;
      read  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (m_req || h_req) begin
            state_q     <= StCheck;
            busy        <= 1'b1;
            gnt_host    <= pick_host;
            last_host_q <= pick_host;
            we_q        <= pick_host ? h_we    : m_we;
            sel_q       <= pick_host ? h_sel   : m_sel;
            adr_q       <= pick_host ? h_adr   : m_adr;
            wdata_q     <= pick_host ? h_wdata : m_wdata;
          end
        end
        StCheck: begin
          if (!sel_ok) begin
            state_q <= StDone;
            if (gnt_host) begin
              h_ack   <= 1'b1;
              h_err   <= 1'b1;
              h_rdata <= 8'd0;
            end else begin
              m_ack   <= 1'b1;
              m_err   <= 1'b1;
              m_rdata <= 8'd0;
            end
          end else begin
            state_q                            <= StAccess;
            adr                                <= adr_q;
            {m2_sel, m1_sel, com_sel, osc_sel} <= sel_q;
            synth_data_in                      <= we_q ? wdata_q : 8'd0;
            write                              <= we_q;
            read                               <= ~we_q;
          end
        end
        StAccess: begin
          if (we_q) begin
            state_q                            <= StDone;
            adr                                <= 7'd0;
            {m2_sel, m1_sel, com_sel, osc_sel} <= 4'd0;
            synth_data_in                      <= 8'd0;
            if (gnt_host) h_ack <= 1'b1;
            else          m_ack <= 1'b1;
          end else begin
            state_q <= StWait;
            cnt_q   <= RdLatCnt;
          end
        end
        StWait: begin
          if (cnt_q == 3'd1) begin
            state_q                            <= StDone;
            adr                                <= 7'd0;
            {m2_sel, m1_sel, com_sel, osc_sel} <= 4'd0;
            synth_data_in                      <= 8'd0;
            if (gnt_host) begin
              h_ack   <= 1'b1;
              h_rdata <= mixer_regdata_out;
            end else begin
              m_ack   <= 1'b1;
              m_rdata <= mixer_regdata_out;
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_synth_reg_arbiter.sv
// Random two-port traffic against three arbiter builds (RD_LAT 1/3, round-robin and MIDI
// priority), checked every cycle against a timestamp-based transaction model.
module tb_synth_reg_arbiter;

  localparam int NI   = 3;
  localparam int NCYC = 1500;

  typedef struct packed {
    logic       we;
    logic [3:0] sel;
    logic [6:0] adr;
    logic [7:0] wdata;
    logic [7:0] rval;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       m_req [NI];
  logic       m_we [NI];
  logic [3:0] m_sel [NI];
  logic [6:0] m_adr [NI];
  logic [7:0] m_wdata [NI];
  logic       m_ack [NI];
  logic       m_err [NI];
  logic [7:0] m_rdata [NI];
  logic       h_req [NI];
  logic       h_we [NI];
  logic [3:0] h_sel [NI];
  logic [6:0] h_adr [NI];
  logic [7:0] h_wdata [NI];
  logic       h_ack [NI];
  logic       h_err [NI];
  logic [7:0] h_rdata [NI];
  logic [6:0] adr [NI];
  logic       write [NI];
  logic       read [NI];
  logic       osc_sel [NI];
  logic       com_sel [NI];
  logic       m1_sel [NI];
  logic       m2_sel [NI];
  logic [7:0] synth_data_in [NI];
  logic [7:0] mixer_regdata_out [NI];
  logic       busy [NI];
  logic       gnt_host [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    synth_reg_arbiter #(
      .RD_LAT   ((g == 1) ? 3 : 1),
      .MIDI_PRIO(g == 2)
    ) u_dut (
      .reg_clk          (clk),
      .reset_reg_N      (rst_n),
      .m_req            (m_req[g]),
      .m_we             (m_we[g]),
      .m_sel            (m_sel[g]),
      .m_adr            (m_adr[g]),
      .m_wdata          (m_wdata[g]),
      .m_ack            (m_ack[g]),
      .m_err            (m_err[g]),
      .m_rdata          (m_rdata[g]),
      .h_req            (h_req[g]),
      .h_we             (h_we[g]),
      .h_sel            (h_sel[g]),
      .h_adr            (h_adr[g]),
      .h_wdata          (h_wdata[g]),
      .h_ack            (h_ack[g]),
      .h_err            (h_err[g]),
      .h_rdata          (h_rdata[g]),
      .adr              (adr[g]),
      .write            (write[g]),
      .read             (read[g]),
      .osc_sel          (osc_sel[g]),
      .com_sel          (com_sel[g]),
      .m1_sel           (m1_sel[g]),
      .m2_sel           (m2_sel[g]),
      .synth_data_in    (synth_data_in[g]),
      .mixer_regdata_out(mixer_regdata_out[g]),
      .busy             (busy[g]),
      .gnt_host         (gnt_host[g])
    );
  end

  int checks = 0;
  int errors = 0;

  // Requester state per instance/port (0 = MIDI, 1 = host)
  txn_t       cur [NI][2];
  bit         pend [NI][2];
  int         nis [NI][2];
  // Transaction model: one active access, described by grant cycle and ack cycle
  bit         act [NI];
  int         t_g [NI];
  int         ack_c [NI];
  bit         win_h [NI];
  bit         legal [NI];
  txn_t       aw [NI];
  bit         last_h [NI];
  bit         exp_gnt [NI];
  logic [7:0] exp_rd [NI][2];
  bit         in_rst;
  bit         rst_done;

  function automatic int lat_of(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic bit prio_of(input int i);
    return i == 2;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic bit dir_txn(input int i, input int p, input int k, output txn_t x);
    x = '0;
    if (i == 0 && p == 0 && k == 0) begin
      x.we = 1'b1; x.sel = 4'b0001; x.adr = 7'h12; x.wdata = 8'hA5; return 1'b1;
    end
    if (i == 0 && p == 1 && k == 0) begin
      x.sel = 4'b0100; x.adr = 7'h05; x.rval = 8'h3C; return 1'b1;
    end
    if (i == 0 && p == 0 && k == 1) begin
      x.we = 1'b1; x.sel = 4'b0011; x.adr = 7'h33; x.wdata = 8'h5A; return 1'b1;
    end
    if (i == 0 && p == 0 && k == 2) begin
      x.sel = 4'b0000; x.adr = 7'h44; return 1'b1;
    end
    if (i == 1 && p == 1 && k == 0) begin
      x.sel = 4'b0100; x.adr = 7'h05; x.rval = 8'h7E; return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic txn_t rand_txn();
    txn_t x;
    int   r;
    r       = $urandom_range(0, 9);
    x.we    = 1'($urandom_range(0, 1));
    x.sel   = (r < 8) ? 4'(1 << (r % 4)) : ((r == 8) ? 4'b0000 : 4'b1010);
    x.adr   = 7'($urandom_range(0, 127));
    x.wdata = 8'($urandom_range(0, 255));
    x.rval  = 8'($urandom_range(0, 254));
    return x;
  endfunction

  task automatic drive_port(input int i, input int p);
    txn_t x;
    x = cur[i][p];
    if (p == 0) begin
      m_req[i] = pend[i][0]; m_we[i] = x.we; m_sel[i] = x.sel;
      m_adr[i] = x.adr;      m_wdata[i] = x.wdata;
    end else begin
      h_req[i] = pend[i][1]; h_we[i] = x.we; h_sel[i] = x.sel;
      h_adr[i] = x.adr;      h_wdata[i] = x.wdata;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      act[i]       = 1'b0;
      last_h[i]    = 1'b1;
      exp_gnt[i]   = 1'b0;
      exp_rd[i][0] = 8'h00;
      exp_rd[i][1] = 8'h00;
    end
  endtask

  task automatic check_cycle(input int c);
    for (int i = 0; i < NI; i++) begin
      bit         bsy, acc, wt, am, ah;
      logic [6:0] eadr;
      logic [3:0] esel;
      string      s;
      s = $sformatf("i%0d", i);
      if (act[i] && c == ack_c[i] + 1) begin
        pend[i][win_h[i]] = 1'b0;
        act[i]            = 1'b0;
      end
      bsy  = act[i] && c >= t_g[i] + 1 && c <= ack_c[i];
      acc  = act[i] && legal[i] && c == t_g[i] + 2;
      wt   = act[i] && legal[i] && !aw[i].we && c > t_g[i] + 2 && c < ack_c[i];
      am   = act[i] && c == ack_c[i] && !win_h[i];
      ah   = act[i] && c == ack_c[i] && win_h[i];
      eadr = (acc || wt) ? aw[i].adr : 7'd0;
      esel = (acc || wt) ? aw[i].sel : 4'd0;
      if ((am || ah) && (!legal[i] || !aw[i].we))
        exp_rd[i][win_h[i]] = legal[i] ? aw[i].rval : 8'h00;
      check_val({s, " busy"}, 32'(busy[i]), 32'(bsy));
      check_val({s, " gnt_host"}, 32'(gnt_host[i]), 32'(exp_gnt[i]));
      check_val({s, " bus adr/sel/wr/rd"},
                32'({adr[i], m2_sel[i], m1_sel[i], com_sel[i], osc_sel[i], write[i], read[i]}),
                32'({eadr, esel, acc && aw[i].we, acc && !aw[i].we}));
      if (!wt)
        check_val({s, " synth_data_in"}, 32'(synth_data_in[i]),
                  32'((acc && aw[i].we) ? aw[i].wdata : 8'h00));
      check_val({s, " m ack/err/rdata"}, 32'({m_ack[i], m_err[i], m_rdata[i]}),
                32'({am, am && !legal[i], exp_rd[i][0]}));
      check_val({s, " h ack/err/rdata"}, 32'({h_ack[i], h_err[i], h_rdata[i]}),
                32'({ah, ah && !legal[i], exp_rd[i][1]}));
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_rst   = 1'b0;
    rst_done = 1'b0;
    for (int i = 0; i < NI; i++) begin
      mixer_regdata_out[i] = 8'hFF;
      for (int p = 0; p < 2; p++) begin
        cur[i][p]  = '0;
        pend[i][p] = 1'b0;
        nis[i][p]  = 0;
        drive_port(i, p);
      end
    end
    model_reset();
    repeat (2) @(negedge clk);
    check_cycle(-10);

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (c == 0 || in_rst) begin
        rst_n  = 1'b1;
        in_rst = 1'b0;
      end
      check_cycle(c);

      // Async reset dropped into a WAIT cycle of the RD_LAT=3 build
      if (!rst_done && c >= 700 && act[1] && legal[1] && !aw[1].we &&
          c > t_g[1] + 2 && c < ack_c[1]) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_cycle(c);
        in_rst   = 1'b1;
        rst_done = 1'b1;
        for (int i = 0; i < NI; i++) begin
          if (!pend[i][0]) begin
            pend[i][0] = 1'b1;
            cur[i][0]  = rand_txn();
          end
        end
      end

      for (int i = 0; i < NI; i++) begin
        for (int p = 0; p < 2; p++) begin
          if (!pend[i][p]) begin
            txn_t x;
            if (dir_txn(i, p, nis[i][p], x)) begin
              pend[i][p] = 1'b1;
              cur[i][p]  = x;
              nis[i][p]++;
            end else if ($urandom_range(0, 3) != 0) begin
              pend[i][p] = 1'b1;
              cur[i][p]  = rand_txn();
              nis[i][p]++;
            end
          end
          drive_port(i, p);
        end
      end

      if (!in_rst) begin
        for (int i = 0; i < NI; i++) begin
          if (!act[i] && (pend[i][0] || pend[i][1])) begin
            bit wh;
            if (pend[i][0] && pend[i][1]) wh = prio_of(i) ? 1'b0 : !last_h[i];
            else                          wh = pend[i][1];
            act[i]     = 1'b1;
            t_g[i]     = c;
            win_h[i]   = wh;
            aw[i]      = cur[i][wh];
            legal[i]   = $countones(aw[i].sel) == 1;
            ack_c[i]   = c + (!legal[i] ? 2 : (aw[i].we ? 3 : 3 + lat_of(i)));
            last_h[i]  = wh;
            exp_gnt[i] = wh;
          end
        end
      end

      for (int i = 0; i < NI; i++) begin
        if (act[i] && legal[i] && !aw[i].we && c == t_g[i] + 2 + lat_of(i))
          mixer_regdata_out[i] = aw[i].rval;
        else
          mixer_regdata_out[i] = 8'hFF;
      end
    end

    check_val("reset_in_wait_exercised", 32'(rst_done), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
